// File: rtl/peak_search.sv
// Frame peak finder: tracks the largest magnitude and its angle/index per frame.
// Optional PEAK_SEARCH_MEAN_EN adds a frame-mean magnitude output (mean_abs_o).
module peak_search #(
  parameter int FRAME_LEN = 64,
  parameter int IDX_W     = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             val_i,
  input  logic [7:0]       abs_i,
  input  logic [15:0]      angle_i,
  input  logic             res_rdy_i,
  output logic             res_val_o,
  output logic [7:0]       peak_abs_o,
  output logic [15:0]      peak_angle_o,
  output logic [IDX_W-1:0] peak_idx_o,
  output logic             busy_o,
`ifdef PEAK_SEARCH_MEAN_EN
  output logic [7:0]       mean_abs_o,
`endif
  output logic             ovf_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [IDX_W-1:0] LAST = IDX_W'(FRAME_LEN - 1);

  state_t           state;
  state_t           state_n;
  logic [IDX_W-1:0] cnt;
  logic             load;
  logic             upd;
  logic             drop;

  logic             res_val_q;
  logic             busy_q;
  logic             ovf_q;
  logic [7:0]       pk_abs_q;
  logic [15:0]      pk_ang_q;
  logic [IDX_W-1:0] pk_idx_q;

`ifdef PEAK_SEARCH_MEAN_EN
  logic [8+IDX_W-1:0] acc_q;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // Next state plus frame start / update / drop strobes
  always_comb begin
    state_n = state;
    load    = 1'b0;
    upd     = 1'b0;
    drop    = 1'b0;
    unique case (state)
      IDLE: begin
        if (val_i) begin
          load    = 1'b1;
          state_n = SEARCH;
        end
      end
      SEARCH: begin
        if (val_i) begin
          upd = 1'b1;
          if (cnt == LAST) state_n = DONE;
        end
      end
      DONE: begin
        // res_val_o is always high here, so res_rdy_i alone completes it
        if (res_rdy_i) begin
          if (val_i) begin
            load    = 1'b1;
            state_n = SEARCH;
          end else begin
            state_n = IDLE;
          end
        end else if (val_i) begin
          drop = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Counter, peak registers, registered status flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt       <= '0;
      pk_abs_q  <= '0;
      pk_ang_q  <= '0;
      pk_idx_q  <= '0;
      res_val_q <= 1'b0;
      busy_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      if (load) begin
        cnt      <= IDX_W'(1);
        pk_abs_q <= abs_i;
        pk_ang_q <= angle_i;
        pk_idx_q <= '0;
      end else if (upd) begin
        // wraps to 0 on the last sample of the frame
        cnt <= cnt + IDX_W'(1);
        if (abs_i > pk_abs_q) begin
          pk_abs_q <= abs_i;
          pk_ang_q <= angle_i;
          pk_idx_q <= cnt;
        end
      end
      if (drop) ovf_q <= 1'b1;
      res_val_q <= (state_n == DONE);
      busy_q    <= (state_n != IDLE);
    end
  end

`ifdef PEAK_SEARCH_MEAN_EN
  // Frame sum; 8+IDX_W bits holds FRAME_LEN full-scale samples
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else if (load) begin
      acc_q <= {{IDX_W{1'b0}}, abs_i};
    end else if (upd) begin
      acc_q <= acc_q + {{IDX_W{1'b0}}, abs_i};
    end
  end

  assign mean_abs_o = acc_q[IDX_W +: 8];
`endif

  assign res_val_o    = res_val_q;
  assign busy_o       = busy_q;
  assign ovf_o        = ovf_q;
  assign peak_abs_o   = pk_abs_q;
  assign peak_angle_o = pk_ang_q;
  assign peak_idx_o   = pk_idx_q;

endmodule

// File: tb/tb_peak_search.sv
// Self-checking bench for peak_search: fixed frame table plus
// random/gapped/backpressure/overflow/reset sequences against a frame model.
module tb_peak_search;

  localparam int N  = 64;
  localparam int IW = 6;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          val_i;
  logic [7:0]    abs_i;
  logic [15:0]   angle_i;
  logic          res_rdy_i;
  logic          res_val_o;
  logic [7:0]    peak_abs_o;
  logic [15:0]   peak_angle_o;
  logic [IW-1:0] peak_idx_o;
  logic          busy_o;
  logic          ovf_o;
`ifdef PEAK_SEARCH_MEAN_EN
  logic [7:0]    mean_abs_o;
`endif

  int errs   = 0;
  int checks = 0;

  int fa [N];
  int fg [N];

  typedef struct {
    int kind;
    int e_abs;
    int e_idx;
    int e_ang;
    int e_mean;
  } vec_t;

  vec_t tbl [4];

  peak_search #(.FRAME_LEN(N), .IDX_W(IW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .val_i        (val_i),
    .abs_i        (abs_i),
    .angle_i      (angle_i),
    .res_rdy_i    (res_rdy_i),
    .res_val_o    (res_val_o),
    .peak_abs_o   (peak_abs_o),
    .peak_angle_o (peak_angle_o),
    .peak_idx_o   (peak_idx_o),
    .busy_o       (busy_o),
`ifdef PEAK_SEARCH_MEAN_EN
    .mean_abs_o   (mean_abs_o),
`endif
    .ovf_o        (ovf_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Frame patterns for the fixed table
  task automatic fill_kind(input int kind);
    for (int i = 0; i < N; i++) begin
      fg[i] = i * 256;
      case (kind)
        0: fa[i] = i;
        1: fa[i] = (i == 5 || i == 40) ? 200 : 10;
        2: fa[i] = 63 - i;
        default: fa[i] = 7;
      endcase
    end
  endtask

  task automatic fill_rand(input int hi);
    for (int i = 0; i < N; i++) begin
      fa[i] = $urandom_range(hi, 0);
      fg[i] = $urandom_range(16'hffff, 0);
    end
  endtask

  // Reference: first index holding the frame maximum, its angle, floor mean
  task automatic model(output int ma, output int mi,
                       output int mg, output int mm);
    int sum;
    ma = -1; mi = 0; sum = 0;
    foreach (fa[i]) begin
      sum += fa[i];
      if (fa[i] > ma) begin
        ma = fa[i];
        mi = i;
      end
    end
    mg = fg[mi];
    mm = sum / N;
  endtask

  task automatic check_res(input string tag, input int ma, input int mi,
                           input int mg, input int mm);
    chk({tag, "_val"}, int'(res_val_o), 1);
    chk({tag, "_abs"}, int'(peak_abs_o), ma);
    chk({tag, "_idx"}, int'(peak_idx_o), mi);
    chk({tag, "_ang"}, int'(peak_angle_o), mg);
`ifdef PEAK_SEARCH_MEAN_EN
    chk({tag, "_mean"}, int'(mean_abs_o), mm);
`else
    if (mm < 0) chk({tag, "_mean"}, mm, 0);
`endif
  endtask

  task automatic check_model(input string tag);
    int ma, mi, mg, mm;
    model(ma, mi, mg, mm);
    check_res(tag, ma, mi, mg, mm);
  endtask

  // Called on a negedge; sends fa/fg[start..N-1] with gap idle cycles between
  task automatic send_frame(input int start, input int gap);
    for (int i = start; i < N; i++) begin
      if (i == N - 1) begin
        chk("early_val", int'(res_val_o), 0);
        chk("mid_busy", int'(busy_o), 1);
      end
      val_i   = 1'b1;
      abs_i   = 8'(fa[i]);
      angle_i = 16'(fg[i]);
      @(negedge clk);
      val_i = 1'b0;
      if (i != N - 1) repeat (gap) @(negedge clk);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_val"}, int'(res_val_o), 0);
    chk({tag, "_busy"}, int'(busy_o), 0);
    chk({tag, "_ovf"}, int'(ovf_o), 0);
    chk({tag, "_abs"}, int'(peak_abs_o), 0);
    chk({tag, "_ang"}, int'(peak_angle_o), 0);
    chk({tag, "_idx"}, int'(peak_idx_o), 0);
`ifdef PEAK_SEARCH_MEAN_EN
    chk({tag, "_mean"}, int'(mean_abs_o), 0);
`endif
  endtask

  initial begin
    tbl[0] = '{0, 63, 63, 16128, 31};
    tbl[1] = '{1, 200, 5, 16'h0500, 15};
    tbl[2] = '{2, 63, 0, 0, 31};
    tbl[3] = '{3, 7, 0, 0, 7};

    rst_n     = 1'b0;
    val_i     = 1'b0;
    abs_i     = '0;
    angle_i   = '0;
    res_rdy_i = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("rst");
    rst_n = 1'b1;
    @(negedge clk);

    // Table frames, downstream always ready
    res_rdy_i = 1'b1;
    for (int t = 0; t < 4; t++) begin
      fill_kind(tbl[t].kind);
      send_frame(0, 0);
      check_res($sformatf("tbl%0d", t), tbl[t].e_abs, tbl[t].e_idx,
                tbl[t].e_ang, tbl[t].e_mean);
      chk("tbl_ovf", int'(ovf_o), 0);
      @(negedge clk);
      chk("tbl_pulse", int'(res_val_o), 0);
      chk("tbl_idle", int'(busy_o), 0);
    end

    // Backpressure: hold the result for 20 cycles
    res_rdy_i = 1'b0;
    fill_kind(0);
    send_frame(0, 0);
    for (int c = 0; c < 20; c++) begin
      check_res("bp", 63, 63, 16128, 31);
      chk("bp_busy", int'(busy_o), 1);
      chk("bp_ovf", int'(ovf_o), 0);
      @(negedge clk);
    end
    res_rdy_i = 1'b1;
    @(negedge clk);
    chk("bp_rel_val", int'(res_val_o), 0);
    chk("bp_rel_busy", int'(busy_o), 0);
    chk("bp_rel_ovf", int'(ovf_o), 0);

    // Overflow: drop 3 samples in DONE, then back-to-back restart
    res_rdy_i = 1'b0;
    fill_kind(1);
    send_frame(0, 0);
    for (int p = 0; p < 3; p++) begin
      val_i   = 1'b1;
      abs_i   = 8'd255;
      angle_i = 16'hbeef;
      @(negedge clk);
      val_i = 1'b0;
      @(negedge clk);
    end
    chk("ovf_set", int'(ovf_o), 1);
    check_res("ovf_hold", 200, 5, 16'h0500, 15);
    fill_rand(255);
    res_rdy_i = 1'b1;
    val_i     = 1'b1;
    abs_i     = 8'(fa[0]);
    angle_i   = 16'(fg[0]);
    @(negedge clk);
    val_i = 1'b0;
    chk("b2b_busy", int'(busy_o), 1);
    chk("b2b_val", int'(res_val_o), 0);
    chk("b2b_abs0", int'(peak_abs_o), fa[0]);
    chk("b2b_idx0", int'(peak_idx_o), 0);
    chk("b2b_ang0", int'(peak_angle_o), fg[0]);
    send_frame(1, 0);
    check_model("b2b");
    chk("ovf_sticky", int'(ovf_o), 1);
    @(negedge clk);

    // Reset at sample 30 of a frame
    fill_rand(255);
    for (int i = 0; i < 30; i++) begin
      val_i   = 1'b1;
      abs_i   = 8'(fa[i]);
      angle_i = 16'(fg[i]);
      @(negedge clk);
    end
    abs_i   = 8'd250;
    rst_n   = 1'b0;
    @(negedge clk);
    val_i = 1'b0;
    rst_n = 1'b1;
    check_zero("midrst");
    fill_rand(255);
    send_frame(0, 0);
    check_model("postrst");
    @(negedge clk);

    // Gapped and random frames
    for (int f = 0; f < 4; f++) begin
      fill_rand((f % 2 == 0) ? 31 : 255);
      send_frame(0, (f < 2) ? 2 : int'($urandom_range(3, 0)));
      check_model($sformatf("rnd%0d", f));
      @(negedge clk);
      chk("rnd_idle", int'(busy_o), 0);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
